lut_ram_wide: RTL and testbench
===============================

LUT_RAM_WIDE -- requirements
Module: lut_ram_wide

Interface
REQ-001 Parameter DEPTH, default 8: number of memory words.
REQ-002 Parameter WIDTH, default 16: bits per memory word, 1..256.
REQ-003 Parameter BASE_ADDR, default 0: first bus address owned by the core.
REQ-004 Parameter READ_ONLY, default 0: when 1, bus writes are ignored and user-port writes remain allowed.
REQ-005 Derived constants: N_CHUNKS = ceil(WIDTH/16); STRIDE = smallest power of 2 >= N_CHUNKS; SPAN = DEPTH*STRIDE; AW = max(1, ceil(log2 DEPTH)).
REQ-006 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  sole clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 addr_i / wdata_i / rdata_i  in  16 each  upstream bus address, write data, read data.
REQ-010 rw_i  in  1  1 = write, 0 = read; valid_i  in  1  bus transaction strobe.
REQ-011 addr_o / wdata_o / rdata_o  out  16 each  downstream bus, registered.
REQ-012 rw_o / valid_o  out  1 each  downstream bus, registered.
REQ-013 user_addr  in  AW  user-side word address.
REQ-014 user_din  in  WIDTH  user-side write data; user_we  in  1  user-side write enable.
REQ-015 user_dout  out  WIDTH  user-side read data, registered.

Function
REQ-016 All bus outputs SHALL equal their inputs delayed by exactly one cycle, except rdata_o when the core services a read (REQ-020).
REQ-017 Decode: offset = addr_i - BASE_ADDR; the access SHALL be mapped only when valid_i=1 and offset < SPAN; word = offset / STRIDE; chunk = offset mod STRIDE; chunk >= N_CHUNKS SHALL be unmapped.
REQ-018 Unmapped accesses SHALL pass through untouched, with no state change.
REQ-019 Mapped write with chunk < N_CHUNKS-1 (READ_ONLY=0): wdata_i SHALL be stored into shadow chunk[chunk]; memory unchanged.
REQ-020 Mapped read: chunk 0 SHALL return mem[word][15:0] on rdata_o next cycle and latch the full mem[word] into a snapshot register; chunk k>0 SHALL return snapshot chunk k.
REQ-021 Mapped write to chunk N_CHUNKS-1 (READ_ONLY=0): mem[word] SHALL be committed atomically as {wdata_i top bits, shadow chunks 0..N-2}; shadow is retained.
REQ-022 With N_CHUNKS=1, every mapped write SHALL commit directly and every read SHALL return live data.
REQ-023 Bits above WIDTH in the top chunk SHALL read as 0 and SHALL be discarded on write.
REQ-024 READ_ONLY=1: bus writes SHALL not modify the shadow or memory; bus reads behave per REQ-020.
REQ-025 User port: user_dout SHALL equal mem[user_addr] one cycle after user_addr is presented, giving old data on a same-cycle write.
REQ-026 user_we=1 SHALL write user_din to mem[user_addr] at the clock edge; user_addr >= DEPTH SHALL be ignored and read 0.
REQ-027 A bus commit and a user write to the same word in the same cycle: the bus commit SHALL win, and the user write is dropped.
REQ-028 A bus read and a write to the same word in the same cycle SHALL return the pre-write data.

Reset
REQ-029 While rst=1: addr_o, wdata_o, rdata_o, rw_o, valid_o, and user_dout SHALL all be 0; shadow and snapshot SHALL be 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 A reset between chunk writes SHALL clear the shadow, so the next commit uses zeros for the lower chunks.

Structure
REQ-032 The bus record widths (16-bit address and data) and the chunk/stride helper functions SHALL live in a shared package.
REQ-033 The decode and datapath SHALL stay in lut_ram_wide.
REQ-034 The storage array with its two ports SHALL be one sub-module, lut_ram_wide_mem: WIDTH x DEPTH, a one-write/one-read user side plus bus-side access, with the priority of REQ-027.

Verification
Scenarios use WIDTH=40, DEPTH=8, BASE_ADDR=0x10, giving N_CHUNKS=3, STRIDE=4, addresses 0x10..0x2F.
REQ-035 Write 0x1111->0x14, 0x2222->0x15, 0x00AB->0x16; read 0x14, 0x15, 0x16 -> rdata_o 0x1111, 0x2222, 0x00AB; user_addr=1 -> user_dout 0xAB22221111.
REQ-036 Read 0x17 (chunk 3) and 0x30 with rdata_i=0xBEEF -> rdata_o 0xBEEF one cycle later; memory unchanged.
REQ-037 user_we with addr 2, data 0x123456789A; bus reads 0x18, 0x19, 0x1A -> 0x789A, 0x3456, 0x0012.
REQ-038 Same cycle: user writes 0xFFFFFFFFFF to word 3, and the bus commits word 3 with shadow 0x0001/0x0002 and top 0x0003 -> mem[3]=0x0300020001.
REQ-039 READ_ONLY=1: bus writes 0x5555 to 0x10..0x12 -> mem[0] keeps its prior user-written value 0x0102030405.
REQ-040 Assert rst after writing chunk 0, then commit chunk 2=0x00CC -> mem[word]=0xCC00000000; all outputs 0 during rst.

Source files
------------

// File: rtl/lut_ram_wide_pkg.sv
// Shared bus record and chunk/stride arithmetic for the wide LUT-RAM core.
// A wide memory word is exposed on the 16-bit bus as a group of chunks.
package lut_ram_wide_pkg;

  localparam int BUS_W = 16;

  typedef struct packed {
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             rw;
    logic             valid;
  } bus_t;

  function automatic int n_chunks(input int width);
    return (width + BUS_W - 1) / BUS_W;
  endfunction

  // Each word occupies a power-of-two address window so decode is a shift and mask.
  function automatic int stride_of(input int n);
    int s;
    s = 1;
    while (s < n) s = s * 2;
    return s;
  endfunction

  function automatic int aw_of(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/lut_ram_wide_mem.sv
// WIDTH x DEPTH storage: registered user read/write port plus an
// asynchronous bus read and a bus write that wins over a colliding user write.
module lut_ram_wide_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    user_addr,
  input  logic [WIDTH-1:0] user_din,
  input  logic             user_we,
  output logic [WIDTH-1:0] user_dout,
  input  logic [AW-1:0]    bus_word,
  input  logic             bus_we,
  input  logic [WIDTH-1:0] bus_wdata,
  output logic [WIDTH-1:0] bus_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             user_ok;
  logic             user_wr;

  assign user_ok   = 32'(user_addr) < 32'(DEPTH);
  assign user_wr   = user_we && user_ok && !(bus_we && (bus_word == user_addr));
  assign bus_rdata = mem[bus_word];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus_we)  mem[bus_word]  <= bus_wdata;
    if (user_wr) mem[user_addr] <= user_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          user_dout <= '0;
    else if (user_ok) user_dout <= mem[user_addr];
    else              user_dout <= '0;
  end

endmodule

// File: rtl/lut_ram_wide.sv
// Bus-pipelined wide LUT RAM: chunked bus access through a write shadow and
// a read snapshot, with a separate user port into the same storage.
module lut_ram_wide
  import lut_ram_wide_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 16,
  parameter int BASE_ADDR = 0,
  parameter int READ_ONLY = 0,
  localparam int AW       = aw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr_i,
  input  logic [15:0]      wdata_i,
  input  logic [15:0]      rdata_i,
  input  logic             rw_i,
  input  logic             valid_i,
  output logic [15:0]      addr_o,
  output logic [15:0]      wdata_o,
  output logic [15:0]      rdata_o,
  output logic             rw_o,
  output logic             valid_o,
  input  logic [AW-1:0]    user_addr,
  input  logic [WIDTH-1:0] user_din,
  input  logic             user_we,
  output logic [WIDTH-1:0] user_dout
);

  localparam int N_CHUNKS = n_chunks(WIDTH);
  localparam int STRIDE   = stride_of(N_CHUNKS);
  localparam int SPAN     = DEPTH * STRIDE;
  localparam int SHIFT    = $clog2(STRIDE);
  localparam int PW       = N_CHUNKS * BUS_W;

  bus_t              bus_q;
  logic [BUS_W-1:0]  offset;
  logic [31:0]       off_ext;
  logic [31:0]       chunk;
  logic [AW-1:0]     word;
  logic              mapped, bus_wr, commit, shadow_wr, bus_rd;
  logic [PW-1:0]     shadow, commit_pad, snap_pad;
  logic [WIDTH-1:0]  snapshot, mem_rdata, mem_wdata;
  logic [BUS_W-1:0]  snap_chunk, rd_chunk;

  // Addresses below BASE_ADDR wrap to large offsets and fall outside SPAN.
  assign offset    = addr_i - 16'(BASE_ADDR);
  assign off_ext   = 32'(offset);
  assign word      = AW'(off_ext >> SHIFT);
  assign chunk     = off_ext & 32'(STRIDE - 1);
  assign mapped    = valid_i && (off_ext < 32'(SPAN)) && (chunk < 32'(N_CHUNKS));
  assign bus_wr    = mapped && rw_i && (READ_ONLY == 0);
  assign commit    = bus_wr && (chunk == 32'(N_CHUNKS - 1));
  assign shadow_wr = bus_wr && !commit;
  assign bus_rd    = mapped && !rw_i;

  // The top chunk of the shadow is never written, so it only ever holds zero.
  always_comb begin
    commit_pad = shadow;
    commit_pad[(N_CHUNKS-1)*BUS_W +: BUS_W] = wdata_i;
  end
  assign mem_wdata = WIDTH'(commit_pad);
  assign snap_pad  = PW'(snapshot);

  always_comb begin
    snap_chunk = '0;
    for (int k = 0; k < N_CHUNKS; k++) begin
      if (chunk == 32'(k)) snap_chunk = snap_pad[k*BUS_W +: BUS_W];
    end
    rd_chunk = (chunk == 32'd0) ? BUS_W'(mem_rdata) : snap_chunk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_q    <= '0;
      shadow   <= '0;
      snapshot <= '0;
    end else begin
      bus_q.addr  <= addr_i;
      bus_q.wdata <= wdata_i;
      bus_q.rw    <= rw_i;
      bus_q.valid <= valid_i;
      bus_q.rdata <= bus_rd ? rd_chunk : rdata_i;
      if (shadow_wr) begin
        for (int k = 0; k < N_CHUNKS - 1; k++) begin
          if (chunk == 32'(k)) shadow[k*BUS_W +: BUS_W] <= wdata_i;
        end
      end
      if (bus_rd && (chunk == 32'd0)) snapshot <= mem_rdata;
    end
  end

  assign addr_o  = bus_q.addr;
  assign wdata_o = bus_q.wdata;
  assign rdata_o = bus_q.rdata;
  assign rw_o    = bus_q.rw;
  assign valid_o = bus_q.valid;

  lut_ram_wide_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .user_addr (user_addr),
    .user_din  (user_din),
    .user_we   (user_we),
    .user_dout (user_dout),
    .bus_word  (word),
    .bus_we    (commit),
    .bus_wdata (mem_wdata),
    .bus_rdata (mem_rdata)
  );

endmodule

// File: tb/tb_lut_ram_wide.sv
// Directed bench for lut_ram_wide at WIDTH=40, DEPTH=8, BASE_ADDR=0x10,
// with a READ_ONLY twin sharing the same inputs.
module tb_lut_ram_wide;

  localparam int W  = 40;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   addr_i, wdata_i, rdata_i;
  logic          rw_i, valid_i;
  logic [15:0]   addr_o, wdata_o, rdata_o;
  logic          rw_o, valid_o;
  logic [15:0]   ro_addr_o, ro_wdata_o, ro_rdata_o;
  logic          ro_rw_o, ro_valid_o;
  logic [AW-1:0] user_addr;
  logic [W-1:0]  user_din, user_dout, ro_user_dout;
  logic          user_we;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lut_ram_wide #(.DEPTH(D), .WIDTH(W), .BASE_ADDR(16'h10), .READ_ONLY(0)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
    .rw_i(rw_i), .valid_i(valid_i), .addr_o(addr_o), .wdata_o(wdata_o),
    .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o), .user_addr(user_addr),
    .user_din(user_din), .user_we(user_we), .user_dout(user_dout)
  );

  lut_ram_wide #(.DEPTH(D), .WIDTH(W), .BASE_ADDR(16'h10), .READ_ONLY(1)) dut_ro (
    .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
    .rw_i(rw_i), .valid_i(valid_i), .addr_o(ro_addr_o), .wdata_o(ro_wdata_o),
    .rdata_o(ro_rdata_o), .rw_o(ro_rw_o), .valid_o(ro_valid_o), .user_addr(user_addr),
    .user_din(user_din), .user_we(user_we), .user_dout(ro_user_dout)
  );

  typedef struct {
    logic        v;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdin;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic v, input logic rw, input logic [15:0] a,
                     input logic [15:0] wd, input logic [15:0] rd);
    valid_i = v;
    rw_i    = rw;
    addr_i  = a;
    wdata_i = wd;
    rdata_i = rd;
  endtask

  task automatic bus_chk(input string name, input logic rw, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] rd, input logic [15:0] exp);
    bus(1'b1, rw, a, wd, rd);
    step();
    chk(name, rdata_o, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " addr_o"}, addr_o, 0);
    chk({tag, " wdata_o"}, wdata_o, 0);
    chk({tag, " rdata_o"}, rdata_o, 0);
    chk({tag, " rw_o"}, rw_o, 0);
    chk({tag, " valid_o"}, valid_o, 0);
    chk({tag, " user_dout"}, user_dout, 0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 16'h0014, 16'h1111, 16'h0A01, 16'h0A01};
    vt[1]  = '{1'b1, 1'b1, 16'h0015, 16'h2222, 16'h0A02, 16'h0A02};
    vt[2]  = '{1'b1, 1'b1, 16'h0016, 16'h00AB, 16'h0A03, 16'h0A03};
    vt[3]  = '{1'b1, 1'b0, 16'h0014, 16'h0000, 16'hDEAD, 16'h1111};
    vt[4]  = '{1'b1, 1'b0, 16'h0015, 16'h0000, 16'hDEAD, 16'h2222};
    vt[5]  = '{1'b1, 1'b0, 16'h0016, 16'h0000, 16'hDEAD, 16'h00AB};
    vt[6]  = '{1'b1, 1'b0, 16'h0017, 16'h0000, 16'hBEEF, 16'hBEEF};
    vt[7]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hBEEF, 16'hBEEF};
    vt[8]  = '{1'b1, 1'b1, 16'h0017, 16'h7777, 16'h1234, 16'h1234};
    vt[9]  = '{1'b1, 1'b1, 16'h000F, 16'h6666, 16'h1235, 16'h1235};
    vt[10] = '{1'b0, 1'b1, 16'h0016, 16'h5A5A, 16'h4321, 16'h4321};
    vt[11] = '{1'b1, 1'b0, 16'h0014, 16'h0000, 16'hDEAD, 16'h1111};
    vt[12] = '{1'b1, 1'b0, 16'h0016, 16'h0000, 16'hDEAD, 16'h00AB};

    // Reset with busy inputs: every output held at zero.
    rst       = 1'b1;
    bus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    user_we   = 1'b0;
    user_addr = 3'd1;
    user_din  = '0;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;

    // Chunked writes, snapshot reads and pass-through cases.
    for (int i = 0; i < 13; i++) begin
      bus(vt[i].v, vt[i].rw, vt[i].addr, vt[i].wdata, vt[i].rdin);
      step();
      chk($sformatf("vec%0d rdata_o", i), rdata_o, vt[i].exp);
      chk($sformatf("vec%0d echo", i), {addr_o, wdata_o, rw_o, valid_o},
          {vt[i].addr, vt[i].wdata, vt[i].rw, vt[i].v});
    end
    chk("user word1", user_dout, 40'hAB22221111);

    // User write, then bus reads of the same word.
    bus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    user_addr = 3'd2;
    user_din  = 40'h123456789A;
    user_we   = 1'b1;
    step();
    user_we = 1'b0;
    step();
    chk("user word2", user_dout, 40'h123456789A);
    bus_chk("rd 0x18", 1'b0, 16'h0018, 16'h0, 16'hDEAD, 16'h789A);
    bus_chk("rd 0x19", 1'b0, 16'h0019, 16'h0, 16'hDEAD, 16'h3456);
    bus_chk("rd 0x1A", 1'b0, 16'h001A, 16'h0, 16'hDEAD, 16'h0012);

    // Bus read and user write to the same word in one cycle: old data on both ports.
    user_din = 40'h0A0B0C0D0E;
    user_we  = 1'b1;
    bus_chk("rd during wr", 1'b0, 16'h0018, 16'h0, 16'hDEAD, 16'h789A);
    chk("user old data", user_dout, 40'h123456789A);
    user_we = 1'b0;
    bus_chk("snap during wr", 1'b0, 16'h0019, 16'h0, 16'hDEAD, 16'h3456);
    chk("user new data", user_dout, 40'h0A0B0C0D0E);

    // Bus commit and user write collide on word 3: bus wins.
    bus_chk("wr 0x1C", 1'b1, 16'h001C, 16'h0001, 16'h0000, 16'h0000);
    bus_chk("wr 0x1D", 1'b1, 16'h001D, 16'h0002, 16'h0000, 16'h0000);
    user_addr = 3'd3;
    user_din  = 40'hFFFFFFFFFF;
    user_we   = 1'b1;
    bus_chk("wr 0x1E", 1'b1, 16'h001E, 16'h0003, 16'h0000, 16'h0000);
    user_we = 1'b0;
    bus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    step();
    chk("collision word3", user_dout, 40'h0300020001);

    // READ_ONLY twin ignores bus writes but still serves reads.
    user_addr = 3'd0;
    user_din  = 40'h0102030405;
    user_we   = 1'b1;
    step();
    user_we = 1'b0;
    bus_chk("wr 0x10", 1'b1, 16'h0010, 16'h5555, 16'h0, 16'h0);
    bus_chk("wr 0x11", 1'b1, 16'h0011, 16'h5555, 16'h0, 16'h0);
    bus_chk("wr 0x12", 1'b1, 16'h0012, 16'h5555, 16'h0, 16'h0);
    bus_chk("rd 0x10", 1'b0, 16'h0010, 16'h0, 16'hDEAD, 16'h5555);
    chk("ro rd 0x10", ro_rdata_o, 16'h0405);
    chk("ro word0", ro_user_dout, 40'h0102030405);
    chk("rw word0", user_dout, 40'h5555555555);

    // Reset between chunk writes clears the shadow; memory survives.
    bus_chk("wr 0x20", 1'b1, 16'h0020, 16'h9999, 16'h0, 16'h0);
    bus(1'b1, 1'b1, 16'h0021, 16'h7777, 16'h3333);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("async rst");
    step();
    chk_zero("rst held");
    rst = 1'b0;
    user_addr = 3'd4;
    bus_chk("wr 0x22", 1'b1, 16'h0022, 16'h00CC, 16'h0, 16'h0);
    bus_chk("snap cleared", 1'b0, 16'h0021, 16'h0, 16'hBEEF, 16'h0000);
    chk("commit after rst", user_dout, 40'hCC00000000);
    bus_chk("rd 0x20", 1'b0, 16'h0020, 16'h0, 16'hBEEF, 16'h0000);
    user_addr = 3'd1;
    bus(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    step();
    chk("mem kept", user_dout, 40'hAB22221111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
